// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory bus arbiter.
package mem_bus_arbiter_pkg;

    // Arbiter FSM states: idle, one bus cycle in flight, or result being held.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        IF_BUSY = 3'd1,
        D_BUSY  = 3'd2,
        IF_DONE = 3'd3,
        D_DONE  = 3'd4
    } arb_state_t;

    // Stall vector bit meaning: Stop holds the stage, NoStop lets it advance.
    localparam logic        Stop     = 1'b1;
    localparam logic        NoStop   = ~Stop;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    // Positions of the owning stages inside the stall vector.
    localparam int STALL_IF_BIT  = 1;
    localparam int STALL_MEM_BIT = 4;

    // True while a bus cycle is outstanding.
    function automatic logic is_busy(input arb_state_t s);
        return (s == IF_BUSY) || (s == D_BUSY);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_bus_watchdog.sv
// Bus watchdog: counts cycles a bus cycle waits for ack and flags expiry.
module bus_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    // Compare in 9 bits so count+1 never wraps before matching the limit.
    localparam logic [8:0] LIMIT = 9'(TIMEOUT);

    logic [7:0] count_reg;
    logic [7:0] count_next;

    // Clear on a fresh bus cycle, otherwise count each waiting cycle.
    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (en) begin
            count_next = count_reg + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Expire in the cycle whose count would reach the limit, so the bus
    // cycle is abandoned after exactly TIMEOUT busy cycles.
    assign expire = en && (({1'b0, count_reg} + 9'd1) == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one Wishbone-style memory port between instruction fetch and
// load/store, sequencing one bus cycle at a time and holding results
// while the owning pipeline stage is stalled.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ack_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_sel_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic [31:0] d_rdata_o,
    output logic        d_ack_o,
    output logic        stall_req_if_o,
    output logic        stall_req_mem_o,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o
);

    arb_state_t  state_reg,  state_next;
    logic        last_d_reg, last_d_next;
    logic        drop_reg,   drop_next;
    logic [31:0] addr_reg,   addr_next;
    logic        we_reg,     we_next;
    logic [3:0]  sel_reg,    sel_next;
    logic [31:0] wdata_reg,  wdata_next;
    logic [31:0] result_reg, result_next;
    logic        err_reg;

    logic wd_clr;
    logic wd_en;
    logic wd_expire;

    // Only the IF and MEM stall bits matter here.
    logic unused_stall_bits;
    assign unused_stall_bits = ^{stall[5], stall[3:2], stall[0]};

    // Any request seen in IDLE starts a new bus cycle; waiting counts only
    // while the slave has not acknowledged.
    assign wd_clr = (state_reg == IDLE) && (if_req_i || d_req_i);
    assign wd_en  = is_busy(state_reg) && !bus_ack_i;

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );

    // Next-state logic: grant, bus completion, hold while stalled, flush.
    always_comb begin
        state_next  = state_reg;
        last_d_next = last_d_reg;
        drop_next   = drop_reg;
        addr_next   = addr_reg;
        we_next     = we_reg;
        sel_next    = sel_reg;
        wdata_next  = wdata_reg;
        result_next = result_reg;

        case (state_reg)
            IDLE: begin
                // Data wins when alone, or on a tie if IF was granted last.
                if (d_req_i && (!if_req_i || !last_d_reg)) begin
                    state_next  = D_BUSY;
                    last_d_next = 1'b1;
                    drop_next   = 1'b0;
                    addr_next   = d_addr_i;
                    we_next     = d_we_i;
                    sel_next    = d_sel_i;
                    wdata_next  = d_wdata_i;
                end else if (if_req_i) begin
                    state_next  = IF_BUSY;
                    last_d_next = 1'b0;
                    drop_next   = 1'b0;
                    addr_next   = if_addr_i;
                    we_next     = 1'b0;
                    sel_next    = 4'hF;
                    wdata_next  = ZeroWord;
                end
            end

            IF_BUSY: begin
                // A flush cannot abort the bus cycle; remember to discard it.
                if (flush) begin
                    drop_next = 1'b1;
                end
                if (bus_ack_i || wd_expire) begin
                    result_next = bus_ack_i ? bus_rdata_i : ZeroWord;
                    drop_next   = 1'b0;
                    state_next  = (drop_reg || flush) ? IDLE : IF_DONE;
                end
            end

            D_BUSY: begin
                if (bus_ack_i || wd_expire) begin
                    result_next = bus_ack_i ? bus_rdata_i : ZeroWord;
                    state_next  = D_DONE;
                end
            end

            IF_DONE: begin
                if (flush || (stall[STALL_IF_BIT] == NoStop)) begin
                    state_next = IDLE;
                end
            end

            D_DONE: begin
                if (stall[STALL_MEM_BIT] == NoStop) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            last_d_reg <= 1'b0;
            drop_reg   <= 1'b0;
            addr_reg   <= ZeroWord;
            we_reg     <= 1'b0;
            sel_reg    <= 4'h0;
            wdata_reg  <= ZeroWord;
            result_reg <= ZeroWord;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            last_d_reg <= last_d_next;
            drop_reg   <= drop_next;
            addr_reg   <= addr_next;
            we_reg     <= we_next;
            sel_reg    <= sel_next;
            wdata_reg  <= wdata_next;
            result_reg <= result_next;
            err_reg    <= wd_expire;
        end
    end

    // Bus cycle control follows the registered state only.
    assign bus_cyc_o   = is_busy(state_reg);
    assign bus_stb_o   = is_busy(state_reg);
    assign bus_we_o    = (state_reg == D_BUSY) && we_reg;
    assign bus_sel_o   = sel_reg;
    assign bus_addr_o  = addr_reg;
    assign bus_wdata_o = wdata_reg;
    assign bus_err_o   = err_reg;

    // Results are presented only while the owning side is in its DONE state.
    assign if_ack_o   = (state_reg == IF_DONE);
    assign d_ack_o    = (state_reg == D_DONE);
    assign if_rdata_o = if_ack_o ? result_reg : ZeroWord;
    assign d_rdata_o  = d_ack_o  ? result_reg : ZeroWord;

    // Keep each requesting stage stalled until its result is available.
    assign stall_req_if_o  = if_req_i && (state_reg != IF_DONE);
    assign stall_req_mem_o = d_req_i  && (state_reg != D_DONE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter (TIMEOUT = 4).
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [3:0]  d_sel_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [31:0] d_rdata_o;
    logic        d_ack_o;
    logic        stall_req_if_o;
    logic        stall_req_mem_o;
    logic        bus_cyc_o;
    logic        bus_stb_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        bus_err_o;

    int errors = 0;
    int checks = 0;

    mem_bus_arbiter #(
        .TIMEOUT (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .if_req_i        (if_req_i),
        .if_addr_i       (if_addr_i),
        .if_rdata_o      (if_rdata_o),
        .if_ack_o        (if_ack_o),
        .d_req_i         (d_req_i),
        .d_we_i          (d_we_i),
        .d_sel_i         (d_sel_i),
        .d_addr_i        (d_addr_i),
        .d_wdata_i       (d_wdata_i),
        .d_rdata_o       (d_rdata_o),
        .d_ack_o         (d_ack_o),
        .stall_req_if_o  (stall_req_if_o),
        .stall_req_mem_o (stall_req_mem_o),
        .bus_cyc_o       (bus_cyc_o),
        .bus_stb_o       (bus_stb_o),
        .bus_we_o        (bus_we_o),
        .bus_sel_o       (bus_sel_o),
        .bus_addr_o      (bus_addr_o),
        .bus_wdata_o     (bus_wdata_o),
        .bus_rdata_i     (bus_rdata_i),
        .bus_ack_i       (bus_ack_i),
        .bus_err_o       (bus_err_o)
    );

    always #5 clk = ~clk;

    // Hard stop in case something hangs.
    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = '0; flush = 1'b0;
        if_req_i = 1'b0; if_addr_i = '0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_sel_i = '0; d_addr_i = '0; d_wdata_i = '0;
        bus_rdata_i = '0; bus_ack_i = 1'b0;
        mid();
        checks++;
        if ({bus_cyc_o, bus_stb_o, bus_we_o, if_ack_o, d_ack_o, bus_err_o, stall_req_if_o, stall_req_mem_o} !== 8'h00) begin
            errors++; $display("FAIL reset_ctrl: got %b want 00000000", {bus_cyc_o, bus_stb_o, bus_we_o, if_ack_o, d_ack_o, bus_err_o, stall_req_if_o, stall_req_mem_o});
        end
        checks++;
        if (bus_sel_o !== 4'h0) begin errors++; $display("FAIL reset_sel: got %h want 0", bus_sel_o); end
        checks++;
        if (bus_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus_addr_o); end
        checks++;
        if (bus_wdata_o !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", bus_wdata_o); end
        checks++;
        if ({if_rdata_o, d_rdata_o} !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h %h want 0 0", if_rdata_o, d_rdata_o); end
        @(posedge clk); #1;
        rst = 1'b1;
        next_cycle();
        $display("test_reset: outputs checked with reset asserted");
    endtask

    task automatic test_tie();
        // cycle 0: both request, data must win the first tie
        if_req_i = 1'b1; if_addr_i = 32'h0000_0400;
        d_req_i = 1'b1; d_we_i = 1'b0; d_sel_i = 4'hF; d_addr_i = 32'h0000_0800;
        mid();
        checks++;
        if ({stall_req_if_o, stall_req_mem_o} !== 2'b11) begin errors++; $display("FAIL tie_c0_stallreq: got %b want 11", {stall_req_if_o, stall_req_mem_o}); end
        next_cycle();
        // cycle 1
        mid();
        checks++;
        if (bus_stb_o !== 1'b1 || bus_addr_o !== 32'h0000_0800) begin errors++; $display("FAIL tie_c1_data_grant: stb=%b addr=%h want 1 00000800", bus_stb_o, bus_addr_o); end
        next_cycle();
        // cycle 2: wait state
        mid();
        checks++;
        if (bus_stb_o !== 1'b1) begin errors++; $display("FAIL tie_c2_stb: got %b want 1", bus_stb_o); end
        next_cycle();
        // cycle 3: ack after two waits
        bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_1111;
        mid();
        checks++;
        if (bus_stb_o !== 1'b1 || d_ack_o !== 1'b0) begin errors++; $display("FAIL tie_c3: stb=%b d_ack=%b want 1 0", bus_stb_o, d_ack_o); end
        next_cycle();
        // cycle 4: D_DONE
        bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
        mid();
        checks++;
        if (d_ack_o !== 1'b1 || d_rdata_o !== 32'h1111_1111) begin errors++; $display("FAIL tie_c4_dack: ack=%b data=%h want 1 11111111", d_ack_o, d_rdata_o); end
        checks++;
        if ({stall_req_if_o, stall_req_mem_o, bus_stb_o} !== 3'b100) begin errors++; $display("FAIL tie_c4_ctrl: got %b want 100", {stall_req_if_o, stall_req_mem_o, bus_stb_o}); end
        next_cycle();
        // cycle 5: IDLE, IF granted here
        d_req_i = 1'b0;
        mid();
        checks++;
        if (bus_stb_o !== 1'b0 || d_ack_o !== 1'b0) begin errors++; $display("FAIL tie_c5_idle: stb=%b d_ack=%b want 0 0", bus_stb_o, d_ack_o); end
        next_cycle();
        // cycle 6: IF bus cycle
        mid();
        checks++;
        if ({bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h0000_0400}) begin
            errors++; $display("FAIL tie_c6_if_cycle: stb=%b we=%b sel=%h addr=%h want 1 0 f 00000400", bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o);
        end
        next_cycle();
        next_cycle();
        // cycle 8: ack
        bus_ack_i = 1'b1; bus_rdata_i = 32'h2222_2222;
        next_cycle();
        // cycle 9: IF_DONE, data requests again
        bus_ack_i = 1'b0; bus_rdata_i = 32'h0; d_req_i = 1'b1; d_addr_i = 32'h0000_0804;
        mid();
        checks++;
        if (if_ack_o !== 1'b1 || if_rdata_o !== 32'h2222_2222) begin errors++; $display("FAIL tie_c9_ifack: ack=%b data=%h want 1 22222222", if_ack_o, if_rdata_o); end
        checks++;
        if ({stall_req_if_o, stall_req_mem_o} !== 2'b01) begin errors++; $display("FAIL tie_c9_stallreq: got %b want 01", {stall_req_if_o, stall_req_mem_o}); end
        next_cycle();
        // cycle 10: IDLE, tie again -> data (IF was granted last)
        if_addr_i = 32'h0000_0404;
        mid();
        checks++;
        if (bus_stb_o !== 1'b0) begin errors++; $display("FAIL tie_c10_idle: stb=%b want 0", bus_stb_o); end
        next_cycle();
        // cycle 11
        bus_ack_i = 1'b1; bus_rdata_i = 32'h3333_3333;
        mid();
        checks++;
        if (bus_stb_o !== 1'b1 || bus_addr_o !== 32'h0000_0804) begin errors++; $display("FAIL tie_c11_second_tie: stb=%b addr=%h want 1 00000804", bus_stb_o, bus_addr_o); end
        next_cycle();
        // cycle 12
        bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
        mid();
        checks++;
        if (d_ack_o !== 1'b1 || d_rdata_o !== 32'h3333_3333) begin errors++; $display("FAIL tie_c12_dack: ack=%b data=%h want 1 33333333", d_ack_o, d_rdata_o); end
        next_cycle();
        if_req_i = 1'b0; d_req_i = 1'b0;
        mid();
        checks++;
        if (d_ack_o !== 1'b0 || bus_stb_o !== 1'b0) begin errors++; $display("FAIL tie_c13_idle: d_ack=%b stb=%b want 0 0", d_ack_o, bus_stb_o); end
        next_cycle();
        $display("test_tie: data, fetch, data granted in turn");
    endtask

    task automatic test_load();
        // cycle 0
        d_req_i = 1'b1; d_we_i = 1'b0; d_sel_i = 4'hF; d_addr_i = 32'h0000_0100;
        mid();
        checks++;
        if (stall_req_mem_o !== 1'b1 || bus_stb_o !== 1'b0) begin errors++; $display("FAIL load_c0: sreq=%b stb=%b want 1 0", stall_req_mem_o, bus_stb_o); end
        next_cycle();
        // cycle 1: zero-wait ack
        bus_ack_i = 1'b1; bus_rdata_i = 32'h1234_5678;
        mid();
        checks++;
        if ({bus_cyc_o, bus_stb_o, bus_we_o, stall_req_mem_o, d_ack_o} !== 5'b11010) begin errors++; $display("FAIL load_c1_ctrl: got %b want 11010", {bus_cyc_o, bus_stb_o, bus_we_o, stall_req_mem_o, d_ack_o}); end
        checks++;
        if (bus_addr_o !== 32'h0000_0100) begin errors++; $display("FAIL load_c1_addr: got %h want 00000100", bus_addr_o); end
        next_cycle();
        // cycle 2
        bus_ack_i = 1'b0; bus_rdata_i = 32'hDEAD_BEEF;
        mid();
        checks++;
        if (d_ack_o !== 1'b1 || d_rdata_o !== 32'h1234_5678) begin errors++; $display("FAIL load_c2_dack: ack=%b data=%h want 1 12345678", d_ack_o, d_rdata_o); end
        checks++;
        if (stall_req_mem_o !== 1'b0 || bus_stb_o !== 1'b0) begin errors++; $display("FAIL load_c2_ctrl: sreq=%b stb=%b want 0 0", stall_req_mem_o, bus_stb_o); end
        next_cycle();
        // cycle 3
        d_req_i = 1'b0; bus_rdata_i = 32'h0;
        mid();
        checks++;
        if (d_ack_o !== 1'b0 || stall_req_mem_o !== 1'b0) begin errors++; $display("FAIL load_c3: ack=%b sreq=%b want 0 0", d_ack_o, stall_req_mem_o); end
        next_cycle();
        $display("test_load: read 12345678 from 00000100");
    endtask

    task automatic test_store();
        d_req_i = 1'b1; d_we_i = 1'b1; d_sel_i = 4'b0011; d_addr_i = 32'h0000_0200; d_wdata_i = 32'h0000_A5A5;
        next_cycle();
        bus_ack_i = 1'b1;
        mid();
        checks++;
        if ({bus_stb_o, bus_we_o, bus_sel_o, bus_wdata_o} !== {1'b1, 1'b1, 4'b0011, 32'h0000_A5A5}) begin
            errors++; $display("FAIL store_c1: stb=%b we=%b sel=%h wdata=%h want 1 1 3 0000a5a5", bus_stb_o, bus_we_o, bus_sel_o, bus_wdata_o);
        end
        next_cycle();
        bus_ack_i = 1'b0;
        mid();
        checks++;
        if (d_ack_o !== 1'b1 || bus_we_o !== 1'b0) begin errors++; $display("FAIL store_c2: ack=%b we=%b want 1 0", d_ack_o, bus_we_o); end
        next_cycle();
        d_req_i = 1'b0; d_we_i = 1'b0; d_wdata_i = '0;
        next_cycle();
        $display("test_store: wrote 0000a5a5 to 00000200 sel 3");
    endtask

    task automatic test_flush();
        // cycle 0
        if_req_i = 1'b1; if_addr_i = 32'h0000_0040;
        next_cycle();
        // cycle 1
        mid();
        checks++;
        if (bus_stb_o !== 1'b1) begin errors++; $display("FAIL flush_c1_stb: got %b want 1", bus_stb_o); end
        next_cycle();
        // cycle 2: flush pulse
        flush = 1'b1;
        next_cycle();
        // cycle 3: fetch withdrawn, bus cycle must continue
        flush = 1'b0; if_req_i = 1'b0;
        mid();
        checks++;
        if (bus_stb_o !== 1'b1) begin errors++; $display("FAIL flush_c3_stb: got %b want 1", bus_stb_o); end
        next_cycle();
        // cycle 4: ack
        bus_ack_i = 1'b1; bus_rdata_i = 32'h3333_0000;
        mid();
        checks++;
        if (if_ack_o !== 1'b0) begin errors++; $display("FAIL flush_c4_ifack: got %b want 0", if_ack_o); end
        next_cycle();
        // cycle 5: must be IDLE; data request granted here
        bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
        d_req_i = 1'b1; d_we_i = 1'b0; d_sel_i = 4'hF; d_addr_i = 32'h0000_0C00;
        mid();
        checks++;
        if (if_ack_o !== 1'b0 || bus_stb_o !== 1'b0) begin errors++; $display("FAIL flush_c5: if_ack=%b stb=%b want 0 0", if_ack_o, bus_stb_o); end
        next_cycle();
        // cycle 6
        bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_0C0C;
        mid();
        checks++;
        if (bus_stb_o !== 1'b1 || bus_addr_o !== 32'h0000_0C00) begin errors++; $display("FAIL flush_c6_regrant: stb=%b addr=%h want 1 00000c00", bus_stb_o, bus_addr_o); end
        next_cycle();
        bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
        next_cycle();
        d_req_i = 1'b0;
        next_cycle();
        $display("test_flush: fetch of 00000040 discarded");
    endtask

    task automatic test_stall_hold();
        // cycle 0
        d_req_i = 1'b1; d_we_i = 1'b0; d_sel_i = 4'hF; d_addr_i = 32'h0000_0010;
        next_cycle();
        // cycle 1
        bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE_BABE;
        next_cycle();
        // cycles 2-4: held; MEM stalled in 2 and 3, only IF stalled in 4
        bus_ack_i = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            stall = (c == 4) ? 6'b000010 : 6'b010000;
            bus_rdata_i = 32'h0BAD_0000 + 32'(c);
            mid();
            checks++;
            if (d_ack_o !== 1'b1 || d_rdata_o !== 32'hCAFE_BABE) begin errors++; $display("FAIL hold_c%0d: ack=%b data=%h want 1 cafebabe", c, d_ack_o, d_rdata_o); end
            next_cycle();
        end
        // cycle 5
        stall = '0; d_req_i = 1'b0; bus_rdata_i = 32'h0;
        mid();
        checks++;
        if (d_ack_o !== 1'b0) begin errors++; $display("FAIL hold_c5_release: ack=%b want 0", d_ack_o); end
        next_cycle();
        $display("test_stall_hold: cafebabe held for 3 cycles");
    endtask

    task automatic test_timeout();
        // cycle 0
        d_req_i = 1'b1; d_we_i = 1'b0; d_sel_i = 4'hF; d_addr_i = 32'h0000_0020;
        bus_rdata_i = 32'hFFFF_FFFF;
        next_cycle();
        // cycles 1-4: slave silent
        for (int c = 1; c <= 4; c++) begin
            mid();
            checks++;
            if (bus_stb_o !== 1'b1 || bus_err_o !== 1'b0) begin errors++; $display("FAIL timeout_c%0d: stb=%b err=%b want 1 0", c, bus_stb_o, bus_err_o); end
            next_cycle();
        end
        // cycle 5
        mid();
        checks++;
        if ({bus_cyc_o, bus_stb_o, bus_err_o, d_ack_o} !== 4'b0011) begin errors++; $display("FAIL timeout_c5_ctrl: got %b want 0011", {bus_cyc_o, bus_stb_o, bus_err_o, d_ack_o}); end
        checks++;
        if (d_rdata_o !== 32'h0) begin errors++; $display("FAIL timeout_c5_data: got %h want 00000000", d_rdata_o); end
        next_cycle();
        // cycle 6
        d_req_i = 1'b0; bus_rdata_i = 32'h0;
        mid();
        checks++;
        if (bus_err_o !== 1'b0 || d_ack_o !== 1'b0) begin errors++; $display("FAIL timeout_c6: err=%b ack=%b want 0 0", bus_err_o, d_ack_o); end
        next_cycle();
        $display("test_timeout: access to 00000020 abandoned after 4 cycles");
    endtask

    task automatic test_async_reset();
        // cycle 0
        d_req_i = 1'b1; d_we_i = 1'b1; d_sel_i = 4'b1100; d_addr_i = 32'h0000_0030; d_wdata_i = 32'h5555_AAAA;
        next_cycle();
        // cycle 1: reset mid-cycle
        mid();
        checks++;
        if (bus_stb_o !== 1'b1) begin errors++; $display("FAIL areset_pre_stb: got %b want 1", bus_stb_o); end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({bus_cyc_o, bus_stb_o, bus_we_o, d_ack_o} !== 4'b0000) begin errors++; $display("FAIL areset_ctrl: got %b want 0000", {bus_cyc_o, bus_stb_o, bus_we_o, d_ack_o}); end
        checks++;
        if (bus_addr_o !== 32'h0 || bus_wdata_o !== 32'h0) begin errors++; $display("FAIL areset_payload: addr=%h wdata=%h want 0 0", bus_addr_o, bus_wdata_o); end
        @(posedge clk); #1;
        rst = 1'b1;
        // IDLE after release, request regranted
        mid();
        checks++;
        if (bus_stb_o !== 1'b0 || d_ack_o !== 1'b0) begin errors++; $display("FAIL areset_idle: stb=%b ack=%b want 0 0", bus_stb_o, d_ack_o); end
        next_cycle();
        bus_ack_i = 1'b1;
        mid();
        checks++;
        if ({bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o} !== {1'b1, 1'b1, 4'b1100, 32'h0000_0030, 32'h5555_AAAA}) begin
            errors++; $display("FAIL areset_regrant: stb=%b we=%b sel=%h addr=%h wdata=%h", bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o);
        end
        next_cycle();
        bus_ack_i = 1'b0;
        mid();
        checks++;
        if (d_ack_o !== 1'b1) begin errors++; $display("FAIL areset_dack: got %b want 1", d_ack_o); end
        next_cycle();
        d_req_i = 1'b0; d_we_i = 1'b0;
        mid();
        checks++;
        if (d_ack_o !== 1'b0) begin errors++; $display("FAIL areset_end: got %b want 0", d_ack_o); end
        next_cycle();
        $display("test_async_reset: store to 00000030 restarted after reset");
    endtask

    initial begin
        test_reset();
        test_tie();
        test_load();
        test_store();
        test_flush();
        test_stall_hold();
        test_timeout();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
